// File: rtl/ecc_scb_pkg.sv
// ecc_scb_pkg: shared types and constants for the ECC result scoreboard.
//   scb_state_t   - checker FSM states
//   ERR_*         - bit positions inside err_flags
//   REG_*         - APB register offsets of the ECC encoder/decoder
//   gm_entry_t    - one golden-model result as held in the result queue
package ecc_scb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2
    } scb_state_t;

    localparam int ERR_MISMATCH  = 0;
    localparam int ERR_TIMING    = 1;   // timeout, early done, or done with no op
    localparam int ERR_OVERFLOW  = 2;
    localparam int ERR_UNDERFLOW = 3;
    localparam int ERR_OVERLAP   = 4;
    localparam int ERR_PRDATA    = 5;
    localparam int ERR_W         = 6;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_DATA     = 4'h4;
    localparam logic [3:0] REG_CW_WIDTH = 4'h8;
    localparam logic [3:0] REG_NOISE    = 4'hC;

    // Data field sized for the widest supported DATA_WIDTH; narrower results
    // are zero-extended on entry, and the constant upper bits synthesise away.
    localparam int GM_DATA_MAX = 64;

    typedef struct packed {
        logic [GM_DATA_MAX-1:0] data;
        logic [1:0]             nerr;
    } gm_entry_t;

endpackage

// File: rtl/ecc_scb_fifo.sv
// ecc_scb_fifo: synchronous FIFO holding golden results until their check.
//   clk, rst (async, active-low)
//   push/din   - write; ignored when full unless a pop happens in the same cycle
//   pop/dout   - read head (dout is the head, valid while !empty); ignored when empty
//   full/empty - occupancy status
module ecc_scb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ecc_result_scoreboard.sv
// ecc_result_scoreboard: run-time checker for the APB ECC encoder/decoder.
// Queues golden results, times each op from the CTRL write to the rise of
// operation_done, and compares DUT results in order.
//   clk, rst (async, active-low)
//   PADDR/PWDATA/PENABLE/PSEL/PWRITE/PRDATA - snooped APB bus
//   data_out/operation_done/num_of_errors   - DUT result
//   gm_valid/gm_data_out/gm_num_of_errors   - golden result push
//   err_flags     - sticky {prdata,overlap,underflow,overflow,timing,mismatch}
//   checked_count - ops compared (saturating)
//   error_count   - error events (saturating)
//   busy          - an op is being timed or checked
// Optional: define ECC_SCB_PRDATA_CHECK_EN to shadow APB writes and check
// read data against them; otherwise err_flags[5] is always 0.
module ecc_result_scoreboard
    import ecc_scb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MIN_LAT         = 1,
    parameter int MAX_LAT         = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic                       PWRITE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    input  logic                       gm_valid,
    input  logic [DATA_WIDTH-1:0]      gm_data_out,
    input  logic [1:0]                 gm_num_of_errors,
    output logic [ERR_W-1:0]           err_flags,
    output logic [CNT_WIDTH-1:0]       checked_count,
    output logic [CNT_WIDTH-1:0]       error_count,
    output logic                       busy
);
    // One spare count so the leaving-state increment past MAX_LAT fits.
    localparam int TW = $clog2(MAX_LAT + 2);

    scb_state_t            state, state_d;
    logic [TW-1:0]         timer, timer_d;
    logic                  done_q, done_rise, start;
    logic [DATA_WIDTH-1:0] smp_data;
    logic [1:0]            smp_nerr;
    logic [ERR_W-1:0]      ev;
    logic [2:0]            ev_sum;
    logic [CNT_WIDTH:0]    err_sum;
    logic                  chk_inc, prdata_ev, unused_pins;
    gm_entry_t             gm_in, head;
    logic                  fifo_full, fifo_empty, fifo_pop;

    assign start     = PSEL & PENABLE & PWRITE & (PADDR[3:0] == REG_CTRL);
    assign done_rise = operation_done & ~done_q;
    assign busy      = (state != IDLE);
    assign fifo_pop  = (state == CHECK);
    assign chk_inc   = (state == CHECK) & ~fifo_empty;
    assign gm_in     = '{data: GM_DATA_MAX'(gm_data_out), nerr: gm_num_of_errors};

    ecc_scb_fifo #(.W($bits(gm_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (gm_valid),
        .din   (gm_in),
        .pop   (fifo_pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef ECC_SCB_PRDATA_CHECK_EN
    logic [AMBA_WORD-1:0] shadow [4];
    logic                 rd_acc;

    assign rd_acc = PSEL & PENABLE & ~PWRITE & (PADDR[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else if (PSEL && PENABLE && PWRITE) begin
            shadow[PADDR[3:2]] <= PWDATA;
        end
    end

    assign prdata_ev   = rd_acc & (PRDATA != shadow[PADDR[3:2]]);
    assign unused_pins = ^PADDR[AMBA_ADDR_WIDTH-1:4];
`else
    assign prdata_ev   = 1'b0;
    assign unused_pins = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PWDATA, PRDATA};
`endif

    always_comb begin
        state_d = state;
        timer_d = timer;
        ev      = '0;
        case (state)
            IDLE: begin
                // A done with no op in flight is a timing error; it wins over
                // a coincident start.
                if (done_rise) begin
                    ev[ERR_TIMING] = 1'b1;
                end else if (start) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                timer_d = timer + 1'b1;
                // A second start is reported but the op keeps its first timing.
                if (start) ev[ERR_OVERLAP] = 1'b1;
                if (done_rise) begin
                    if (timer < TW'(MIN_LAT)) ev[ERR_TIMING] = 1'b1;
                    state_d = CHECK;
                end else if (timer == TW'(MAX_LAT)) begin
                    ev[ERR_TIMING] = 1'b1;
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (fifo_empty) begin
                    ev[ERR_UNDERFLOW] = 1'b1;
                end else if (head.nerr != smp_nerr ||
                             (smp_nerr != 2'd2 && head.data != GM_DATA_MAX'(smp_data))) begin
                    // Data is meaningless for an uncorrectable (2-error) result.
                    ev[ERR_MISMATCH] = 1'b1;
                end
                timer_d = '0;
                state_d = start ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        ev[ERR_OVERFLOW] = gm_valid & fifo_full & ~fifo_pop;
        ev[ERR_PRDATA]   = prdata_ev;
    end

    assign ev_sum  = 3'($countones(ev));
    assign err_sum = {1'b0, error_count} + (CNT_WIDTH+1)'(ev_sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer         <= '0;
            done_q        <= 1'b0;
            smp_data      <= '0;
            smp_nerr      <= '0;
            err_flags     <= '0;
            checked_count <= '0;
            error_count   <= '0;
        end else begin
            state  <= state_d;
            timer  <= timer_d;
            done_q <= operation_done;
            if (done_rise) begin
                smp_data <= data_out;
                smp_nerr <= num_of_errors;
            end
            err_flags <= err_flags | ev;
            if (chk_inc && checked_count != '1) checked_count <= checked_count + 1'b1;
            error_count <= err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
        end
    end

endmodule
